// File: rtl/gh_pkg.sv
// Shared definitions for the Guitar Hero strum scorer.
//   gh_state_t  : evaluation FSM states (IDLE, EVAL, COOLDOWN, RELEASE)
//   STREAK_MAX  : streak counter saturation value
//   MULT_STEP   : streak length per multiplier step
//   MULT_MAX    : largest streak multiplier
//   streak_mult : multiplier for a given pre-hit streak (1x..4x)
package gh_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        COOLDOWN = 2'd2,
        RELEASE  = 2'd3
    } gh_state_t;

    localparam int STREAK_MAX = 255;
    localparam int MULT_STEP  = 10;
    localparam int MULT_MAX   = 4;

    // Every MULT_STEP consecutive hits bump the multiplier by one, capped at MULT_MAX.
    function automatic logic [2:0] streak_mult(input logic [7:0] streak_val);
        logic [7:0] step;
        step = streak_val / 8'(MULT_STEP);
        if (step >= 8'(MULT_MAX - 1))
            return 3'(MULT_MAX);
        return 3'(step) + 3'd1;
    endfunction

endpackage

// File: rtl/gh_lane_debouncer.sv
// One fret lane: synchroniser chain followed by a stability debouncer.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   raw    in  asynchronous raw button level
//   stable out debounced button level (accepted after DEBOUNCE_CYC stable cycles)
module gh_lane_debouncer #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    import gh_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   candidate;
    logic [CNT_W-1:0]       stable_cnt;
    logic                   synced;

    assign synced = sync_chain[SYNC_STAGES-1];

    // Metastability chain; bit 0 faces the asynchronous input.
    always_ff @(posedge clock) begin
        if (reset)
            sync_chain <= '0;
        else
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
    end

    // Any change of the synced level restarts the count; the candidate is
    // accepted on the cycle that completes DEBOUNCE_CYC identical samples.
    // The counter parks at CNT_MAX so it never wraps while the level holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            candidate  <= 1'b0;
            stable_cnt <= '0;
            stable     <= 1'b0;
        end else if (synced != candidate) begin
            candidate  <= synced;
            stable_cnt <= '0;
        end else begin
            if (stable_cnt != CNT_MAX)
                stable_cnt <= stable_cnt + 1'b1;
            if (stable_cnt == CNT_ACC)
                stable <= candidate;
        end
    end

endmodule

// File: rtl/gh_strum_scorer.sv
// Note-hit scorer: synchronises strum and fret buttons, evaluates each strum
// against the lane intersection mask and keeps a saturating score and streak.
// Optional feature macro: GH_STREAK_MULT_EN (streak-based 1x..4x multiplier).
// Ports:
//   clock         in   system clock
//   reset         in   synchronous active-high reset
//   buttons       in   raw fret buttons (async), LANES wide
//   intersections in   note-at-strike-line mask, synchronous
//   strum         in   raw strum bar (async)
//   score_clear   in   synchronous clear of score and streak
//   score         out  registered score, saturating
//   streak        out  consecutive hits, saturating at 255
//   hit_pulse     out  one-cycle pulse per hit
//   miss_pulse    out  one-cycle pulse per miss
module gh_strum_scorer #(
    parameter int LANES        = 4,
    parameter int SCORE_W      = 32,
    parameter int HIT_POINTS   = 10,
    parameter int MISS_PENALTY = 0,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int COOLDOWN_CYC = 500
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LANES-1:0]   buttons,
    input  logic [LANES-1:0]   intersections,
    input  logic               strum,
    input  logic               score_clear,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic               hit_pulse,
    output logic               miss_pulse
);
    import gh_pkg::*;

    localparam int EXT_W  = SCORE_W + 8;
    localparam int COOL_W = $clog2(COOLDOWN_CYC + 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYC - 1);

    logic [LANES-1:0]       btn_db;
    logic [SYNC_STAGES-1:0] strum_chain;
    logic                   strum_cur;
    logic                   strum_prev;
    logic                   strum_rise;
    gh_state_t              state, next_state;
    logic [COOL_W-1:0]      cool_cnt;
    logic [LANES-1:0]       int_q;
    logic                   is_hit;
    logic [2:0]             mult;
    logic [EXT_W-1:0]       score_ext;
    logic [EXT_W-1:0]       score_max_ext;
    logic [EXT_W-1:0]       pen_ext;
    logic [EXT_W-1:0]       hit_sum;
    logic [SCORE_W-1:0]     hit_score;
    logic [SCORE_W-1:0]     miss_score;
    logic [7:0]             hit_streak;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            gh_lane_debouncer #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_lane (
                .clock (clock),
                .reset (reset),
                .raw   (buttons[g]),
                .stable(btn_db[g])
            );
        end
    endgenerate

    assign strum_cur = strum_chain[SYNC_STAGES-1];

    // The rise flag is registered, adding the cycle between the synced edge
    // and the IDLE->EVAL transition that gives the documented latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            strum_chain <= '0;
            strum_prev  <= 1'b0;
            strum_rise  <= 1'b0;
        end else begin
            strum_chain <= {strum_chain[SYNC_STAGES-2:0], strum};
            strum_prev  <= strum_cur;
            strum_rise  <= strum_cur & ~strum_prev;
        end
    end

    // Next-state logic; the bar must drop before the FSM rearms, so holding it never retriggers.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (strum_rise) next_state = EVAL;
            EVAL:     next_state = COOLDOWN;
            COOLDOWN: if (cool_cnt == '0) next_state = RELEASE;
            RELEASE:  if (!strum_cur) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // State register, cooldown counter and the intersection snapshot taken on the triggering edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cool_cnt <= '0;
            int_q    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && strum_rise)
                int_q <= intersections;
            if (state == EVAL)
                cool_cnt <= COOL_LOAD;
            else if (state == COOLDOWN && cool_cnt != '0)
                cool_cnt <= cool_cnt - 1'b1;
        end
    end

`ifdef GH_STREAK_MULT_EN
    assign mult = streak_mult(streak);
`else
    assign mult = 3'd1;
`endif

    // Score arithmetic is done 8 bits wider than the register so both
    // saturation at the top and flooring at zero are detected without wrap.
    always_comb begin
        is_hit        = (int_q != '0) && (btn_db == int_q);
        score_ext     = {8'd0, score};
        score_max_ext = {8'd0, {SCORE_W{1'b1}}};
        pen_ext       = EXT_W'(MISS_PENALTY);
        hit_sum       = score_ext + EXT_W'(HIT_POINTS) * EXT_W'(mult);
        hit_score     = (hit_sum > score_max_ext) ? {SCORE_W{1'b1}} : SCORE_W'(hit_sum);
        miss_score    = (score_ext >= pen_ext) ? SCORE_W'(score_ext - pen_ext) : '0;
        hit_streak    = (streak == 8'(STREAK_MAX)) ? streak : streak + 8'd1;
    end

    // Pulses follow the evaluation even when score_clear overrides the score update.
    always_ff @(posedge clock) begin
        if (reset) begin
            score      <= '0;
            streak     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= (state == EVAL) && is_hit;
            miss_pulse <= (state == EVAL) && !is_hit;
            if (score_clear) begin
                score  <= '0;
                streak <= '0;
            end else if (state == EVAL) begin
                if (is_hit) begin
                    score  <= hit_score;
                    streak <= hit_streak;
                end else begin
                    score  <= miss_score;
                    streak <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gh_strum_scorer.sv
// Self-checking bench for gh_strum_scorer: two instances (wide score with a
// miss penalty, and an 8-bit score for saturation) share one stimulus stream.
module tb_gh_strum_scorer;

    localparam int S    = 2;
    localparam int DEB  = 4;
    localparam int COOL = 8;
    localparam int OFS  = 16;
    localparam int MAXC = 20000;
    localparam int INF  = 1 << 30;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  buttons;
    logic [3:0]  intersections;
    logic        strum;
    logic        score_clear;
    logic [31:0] score_a;
    logic [7:0]  streak_a;
    logic        hit_a, miss_a;
    logic [7:0]  score_b;
    logic [7:0]  streak_b;
    logic        hit_b, miss_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    gh_strum_scorer #(
        .LANES(4), .SCORE_W(32), .HIT_POINTS(10), .MISS_PENALTY(5),
        .SYNC_STAGES(S), .DEBOUNCE_CYC(DEB), .COOLDOWN_CYC(COOL)
    ) dut_a (
        .clock(clock), .reset(reset), .buttons(buttons), .intersections(intersections),
        .strum(strum), .score_clear(score_clear), .score(score_a), .streak(streak_a),
        .hit_pulse(hit_a), .miss_pulse(miss_a)
    );

    gh_strum_scorer #(
        .LANES(4), .SCORE_W(8), .HIT_POINTS(200), .MISS_PENALTY(0),
        .SYNC_STAGES(S), .DEBOUNCE_CYC(DEB), .COOLDOWN_CYC(COOL)
    ) dut_b (
        .clock(clock), .reset(reset), .buttons(buttons), .intersections(intersections),
        .strum(strum), .score_clear(score_clear), .score(score_b), .streak(streak_b),
        .hit_pulse(hit_b), .miss_pulse(miss_b)
    );

    always #5 clock = ~clock;

    // Reference state: index 0 models dut_a, index 1 models dut_b.
    longint m_score [2];
    int     m_streak[2];
    bit     m_hit, m_miss;
    int     raw_h [MAXC];
    int     ints_h[MAXC];
    int     btn_h [MAXC];
    int     t = 0;
    int     idle_at = 0;
    int     cool_end = 0;

    function automatic longint next_score(input longint sc, input int sk, input bit hit,
                                          input int pts, input int pen, input int w);
        longint top;
        int     mul;
        top = (longint'(1) << w) - 1;
`ifdef GH_STREAK_MULT_EN
        mul = 1 + ((sk / 10) > 3 ? 3 : (sk / 10));
`else
        mul = 1;
`endif
        if (hit)
            return (sc + pts * mul > top) ? top : sc + pts * mul;
        return (sc < pen) ? 0 : sc - pen;
    endfunction

    // Timeline model: an evaluation lands S+2 edges after a raw strum rise,
    // provided the scorer had been idle; it rearms only once the cooldown has
    // expired and the synchronised bar reads low.
    initial begin
        for (int i = 0; i < MAXC; i++) begin
            raw_h[i] = 0; ints_h[i] = 0; btn_h[i] = 0;
        end
        forever begin
            @(posedge clock);
            t = t + 1;
            raw_h[t + OFS]  = strum;
            ints_h[t + OFS] = intersections;
            btn_h[t + OFS]  = buttons;
            m_hit  = 0;
            m_miss = 0;
            if (reset) begin
                for (int j = t + OFS - S - 4; j <= t + OFS; j++) raw_h[j] = 0;
                m_score[0] = 0; m_score[1] = 0;
                m_streak[0] = 0; m_streak[1] = 0;
                idle_at = t;
            end else begin
                if (idle_at <= t - 2 && raw_h[t + OFS - 2 - S] == 1 && raw_h[t + OFS - 3 - S] == 0) begin
                    bit hit;
                    hit = (ints_h[t + OFS - 1] != 0) && (btn_h[t + OFS - 1] == ints_h[t + OFS - 1]);
                    m_score[0] = next_score(m_score[0], m_streak[0], hit, 10, 5, 32);
                    m_score[1] = next_score(m_score[1], m_streak[1], hit, 200, 0, 8);
                    for (int d = 0; d < 2; d++)
                        m_streak[d] = hit ? ((m_streak[d] == 255) ? 255 : m_streak[d] + 1) : 0;
                    m_hit  = hit;
                    m_miss = !hit;
                    idle_at  = INF;
                    cool_end = t + COOL;
                end else if (idle_at == INF && t > cool_end && raw_h[t + OFS - S] == 0) begin
                    idle_at = t;
                end
                if (score_clear) begin
                    m_score[0] = 0; m_score[1] = 0;
                    m_streak[0] = 0; m_streak[1] = 0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare both instances against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check_output("a.score",  64'(score_a),  64'(m_score[0]));
                check_output("a.streak", 64'(streak_a), 64'(m_streak[0]));
                check_output("a.hit",    64'(hit_a),    64'(m_hit));
                check_output("a.miss",   64'(miss_a),   64'(m_miss));
                check_output("b.score",  64'(score_b),  64'(m_score[1]));
                check_output("b.streak", 64'(streak_b), 64'(m_streak[1]));
                check_output("b.hit",    64'(hit_b),    64'(m_hit));
                check_output("b.miss",   64'(miss_b),   64'(m_miss));
            end
        end
    end

    task automatic set_frets(input logic [3:0] b, input logic [3:0] i);
        @(posedge clock); #1;
        buttons = b;
        intersections = i;
        repeat (12) @(posedge clock);
    endtask

    task automatic apply_stimulus(input int hold);
        @(posedge clock); #1;
        strum = 1'b1;
        repeat (hold) @(posedge clock);
        #1 strum = 1'b0;
        repeat (20) @(posedge clock);
    endtask

    initial begin
        reset = 1'b1; buttons = '0; intersections = '0; strum = 1'b0; score_clear = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk_en = 1;

        // Idle after reset
        repeat (100) @(posedge clock);
        @(negedge clock);
        check_output("idle.score", 64'(score_a), 64'd0);
        check_output("idle.streak", 64'(streak_a), 64'd0);

        // Single hit and its exact latency
        set_frets(4'b0101, 4'b0101);
        @(posedge clock); #1 strum = 1'b1;
        @(posedge clock);
        repeat (S + 1) @(posedge clock);
        @(negedge clock);
        check_output("lat.early", 64'(hit_a), 64'd0);
        @(posedge clock);
        @(negedge clock);
        check_output("lat.hit", 64'(hit_a), 64'd1);
        repeat (20 - (S + 2)) @(posedge clock);
        #1 strum = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check_output("hit.score", 64'(score_a), 64'd10);
        check_output("hit.streak", 64'(streak_a), 64'd1);

        // Misses with penalty and floor at zero
        set_frets(4'b0001, 4'b0011);
        apply_stimulus(4);
        @(negedge clock);
        check_output("miss1.score", 64'(score_a), 64'd5);
        check_output("miss1.streak", 64'(streak_a), 64'd0);
        apply_stimulus(4);
        @(negedge clock);
        check_output("miss2.score", 64'(score_a), 64'd0);
        apply_stimulus(4);
        @(negedge clock);
        check_output("miss3.score", 64'(score_a), 64'd0);

        // Twelve consecutive hits
        set_frets(4'b1000, 4'b1000);
        for (int n = 0; n < 12; n++) apply_stimulus(4);
        @(negedge clock);
`ifdef GH_STREAK_MULT_EN
        check_output("run12.score", 64'(score_a), 64'd140);
`else
        check_output("run12.score", 64'(score_a), 64'd120);
`endif
        check_output("run12.streak", 64'(streak_a), 64'd12);

        // Strum chatter during cooldown gives a single evaluation
        @(posedge clock); #1 score_clear = 1'b1;
        @(posedge clock); #1 score_clear = 1'b0;
        for (int n = 0; n < 5; n++) begin
            strum = (n % 2 == 0);
            repeat (2) @(posedge clock);
            #1;
        end
        strum = 1'b0;
        repeat (25) @(posedge clock);
        @(negedge clock);
        check_output("chatter.streak", 64'(streak_a), 64'd1);
        check_output("chatter.score", 64'(score_a), 64'd10);

        // score_clear coinciding with the evaluation edge
        @(posedge clock); #1 strum = 1'b1;
        @(posedge clock);
        repeat (S + 1) @(posedge clock);
        #1 score_clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_output("clr.hit", 64'(hit_a), 64'd1);
        check_output("clr.score", 64'(score_a), 64'd0);
        check_output("clr.streak", 64'(streak_a), 64'd0);
        score_clear = 1'b0;
        repeat (20) @(posedge clock);
        #1 strum = 1'b0;
        repeat (20) @(posedge clock);

        // 8-bit score saturates
        apply_stimulus(4);
        apply_stimulus(4);
        @(negedge clock);
        check_output("sat.score", 64'(score_b), 64'd255);
        check_output("sat.a_score", 64'(score_a), 64'd20);

        // Reset during a pending evaluation
        @(posedge clock); #1 strum = 1'b1;
        @(posedge clock);
        repeat (S + 1) @(posedge clock);
        #1 reset = 1'b1; strum = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_output("rst.hit", 64'(hit_a), 64'd0);
        check_output("rst.score", 64'(score_a), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check_output("rst.after", 64'(streak_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
